// File: rtl/parking_gate_sequencer.sv
// parking_gate_sequencer
// Serialises car entry/exit requests from NUM_GATES gates onto the single event
// interface of the parking occupancy counter. Each request is admitted or rejected
// against the counter's live vacancy/occupancy outputs. The requesting gate then
// receives a one-cycle ack together with an accept flag.
// Transaction flow: IDLE (arbitrate, latch) -> ISSUE (decide, pulse counter)
//                   -> SETTLE (ack gate, rotate pointer) -> IDLE.
// Optional build macro: EXIT_PRIORITY_EN
//   When defined, pending exits win over pending entries. Round robin applies
//   within each set, and both sets share one pointer.
//   When undefined, plain round robin runs over all requests.
module parking_gate_sequencer #(
    parameter int NUM_GATES = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_GATES-1:0] gate_req,
    input  logic [NUM_GATES-1:0] gate_is_exit,
    input  logic [NUM_GATES-1:0] gate_is_uni,
    output logic [NUM_GATES-1:0] gate_ack,
    output logic                 gate_accept,
    input  logic                 uni_is_vacated_space,
    input  logic                 is_vacated_space,
    input  logic [CNT_W-1:0]     uni_parked_car,
    input  logic [CNT_W-1:0]     parked_car,
    output logic                 car_entered,
    output logic                 is_uni_car_enterd,
    output logic                 car_exited,
    output logic                 is_uni_car_exited,
    output logic                 busy
);

    localparam int IDX_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    // First requesting gate found when scanning upward from ptr, with wrap-around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_GATES-1:0] req,
                                                 input logic [IDX_W-1:0]     ptr);
        logic [IDX_W-1:0] win;
        logic [IDX_W:0]   sum;
        logic             found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_GATES; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_GATES)) begin
                sum = sum - (IDX_W+1)'(NUM_GATES);
            end else begin
                sum = sum;
            end
            if (!found && req[sum[IDX_W-1:0]]) begin
                win   = sum[IDX_W-1:0];
                found = 1'b1;
            end else begin
                win   = win;
            end
        end
        return win;
    endfunction

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 is_exit_q, is_exit_d;
    logic                 is_uni_q, is_uni_d;
    logic                 ok_q, ok_d;
    logic [NUM_GATES-1:0] gate_ack_q, gate_ack_d;
    logic                 gate_accept_q, gate_accept_d;
    logic                 car_entered_q, car_entered_d;
    logic                 uni_entered_q, uni_entered_d;
    logic                 car_exited_q, car_exited_d;
    logic                 uni_exited_q, uni_exited_d;
    logic                 busy_q, busy_d;
    logic [NUM_GATES-1:0] pick_req_s;
    logic [IDX_W-1:0]     win_s;
    logic                 ok_s;

    // Select the request set that takes part in arbitration and pick the winner.
    always_comb begin
        pick_req_s = gate_req;
`ifdef EXIT_PRIORITY_EN
        if ((gate_req & gate_is_exit) != {NUM_GATES{1'b0}}) begin
            pick_req_s = gate_req & gate_is_exit;
        end else begin
            pick_req_s = gate_req;
        end
`endif
        win_s = rr_pick(pick_req_s, rr_ptr_q);
    end

    // Admission decision for the latched event, using the counter's current outputs.
    always_comb begin
        ok_s = 1'b0;
        if (is_exit_q) begin
            ok_s = is_uni_q ? (uni_parked_car != {CNT_W{1'b0}})
                            : (parked_car != {CNT_W{1'b0}});
        end else begin
            ok_s = is_uni_q ? uni_is_vacated_space : is_vacated_space;
        end
    end

    // Next-state logic and next values of all registered outputs.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rr_ptr_d      = rr_ptr_q;
        is_exit_d     = is_exit_q;
        is_uni_d      = is_uni_q;
        ok_d          = ok_q;
        gate_ack_d    = {NUM_GATES{1'b0}};
        gate_accept_d = 1'b0;
        car_entered_d = 1'b0;
        uni_entered_d = 1'b0;
        car_exited_d  = 1'b0;
        uni_exited_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|gate_req) begin
                    idx_d     = win_s;
                    is_exit_d = gate_is_exit[win_s];
                    is_uni_d  = gate_is_uni[win_s];
                    state_d   = ST_ISSUE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                ok_d          = ok_s;
                car_entered_d = ok_s & ~is_exit_q;
                uni_entered_d = ok_s & ~is_exit_q & is_uni_q;
                car_exited_d  = ok_s & is_exit_q;
                uni_exited_d  = ok_s & is_exit_q & is_uni_q;
                state_d       = ST_SETTLE;
            end
            ST_SETTLE: begin
                gate_ack_d[idx_q] = 1'b1;
                gate_accept_d     = ok_q;
                if (idx_q == IDX_W'(NUM_GATES - 1)) begin
                    rr_ptr_d = {IDX_W{1'b0}};
                end else begin
                    rr_ptr_d = idx_q + IDX_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, latched transaction context and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= {IDX_W{1'b0}};
            rr_ptr_q      <= {IDX_W{1'b0}};
            is_exit_q     <= 1'b0;
            is_uni_q      <= 1'b0;
            ok_q          <= 1'b0;
            gate_ack_q    <= {NUM_GATES{1'b0}};
            gate_accept_q <= 1'b0;
            car_entered_q <= 1'b0;
            uni_entered_q <= 1'b0;
            car_exited_q  <= 1'b0;
            uni_exited_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rr_ptr_q      <= rr_ptr_d;
            is_exit_q     <= is_exit_d;
            is_uni_q      <= is_uni_d;
            ok_q          <= ok_d;
            gate_ack_q    <= gate_ack_d;
            gate_accept_q <= gate_accept_d;
            car_entered_q <= car_entered_d;
            uni_entered_q <= uni_entered_d;
            car_exited_q  <= car_exited_d;
            uni_exited_q  <= uni_exited_d;
            busy_q        <= busy_d;
        end
    end

    assign gate_ack          = gate_ack_q;
    assign gate_accept       = gate_accept_q;
    assign car_entered       = car_entered_q;
    assign is_uni_car_enterd = uni_entered_q;
    assign car_exited        = car_exited_q;
    assign is_uni_car_exited = uni_exited_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Testbench for parking_gate_sequencer.
// Each transaction is predicted by a transaction-level model: winner by rotating
// search from the model pointer, then admission by the vacancy/occupancy rules.
// Optional build macro EXIT_PRIORITY_EN changes the model's winner selection.
module tb_parking_gate_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  gate_req, gate_is_exit, gate_is_uni, gate_ack;
    logic        gate_accept, uni_is_vacated_space, is_vacated_space;
    logic [31:0] uni_parked_car, parked_car;
    logic        car_entered, is_uni_car_enterd, car_exited, is_uni_car_exited, busy;

    int          checks = 0;
    int          errors = 0;
    int          rr_m = 0;
    int          entered_cnt = 0;
    logic [3:0]  last_ack;
    logic        last_accept;

    always #5 clk = ~clk;

    parking_gate_sequencer #(.NUM_GATES(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .gate_req(gate_req), .gate_is_exit(gate_is_exit), .gate_is_uni(gate_is_uni),
        .gate_ack(gate_ack), .gate_accept(gate_accept),
        .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
        .uni_parked_car(uni_parked_car), .parked_car(parked_car),
        .car_entered(car_entered), .is_uni_car_enterd(is_uni_car_enterd),
        .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
        .busy(busy)
    );

    function automatic logic bit_of(input logic [3:0] v, input int g);
        logic [3:0] t;
        t = v >> g;
        return t[0];
    endfunction

    // Winner: first requesting gate from the pointer onwards (exits first if enabled).
    function automatic int model_winner(input logic [3:0] req, input logic [3:0] ex, input int rr);
        logic [3:0] pool;
        pool = req;
`ifdef EXIT_PRIORITY_EN
        if ((req & ex) != 4'd0) pool = req & ex;
`endif
        for (int k = 0; k < 4; k++) begin
            if (bit_of(pool, (rr + k) % 4)) return (rr + k) % 4;
        end
        return 0;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        gate_req = 4'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rr_m = 0;
    endtask

    // One full transaction; req must be non-zero and the DUT idle at entry.
    task automatic do_txn(input logic [3:0] req, input logic [3:0] ex, input logic [3:0] uni,
                          input logic uv, input logic v, input logic [31:0] up,
                          input logic [31:0] p, input bit scramble);
        int         w;
        logic       w_ex, w_uni, ok;
        logic [3:0] exp_ack;
        gate_req = req; gate_is_exit = ex; gate_is_uni = uni;
        uni_is_vacated_space = uv; is_vacated_space = v;
        uni_parked_car = up; parked_car = p;
        w       = model_winner(req, ex, rr_m);
        w_ex    = bit_of(ex, w);
        w_uni   = bit_of(uni, w);
        ok      = w_ex ? (w_uni ? (up != 32'd0) : (p != 32'd0)) : (w_uni ? uv : v);
        exp_ack = 4'b0001 << w;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({busy, car_entered, car_exited, gate_ack} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL issue_phase: busy/ent/ext/ack=%b %b %b %b expected 1 0 0 0000",
                     busy, car_entered, car_exited, gate_ack);
        end
        if (scramble) begin
            gate_req = 4'($urandom); gate_is_exit = 4'($urandom); gate_is_uni = 4'($urandom);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if ({car_entered, is_uni_car_enterd} !== {ok && !w_ex, ok && !w_ex && w_uni}) begin
            errors++;
            $display("FAIL entry_pulse gate%0d: got %b%b expected %b%b", w, car_entered,
                     is_uni_car_enterd, ok && !w_ex, ok && !w_ex && w_uni);
        end
        checks++;
        if ({car_exited, is_uni_car_exited} !== {ok && w_ex, ok && w_ex && w_uni}) begin
            errors++;
            $display("FAIL exit_pulse gate%0d: got %b%b expected %b%b", w, car_exited,
                     is_uni_car_exited, ok && w_ex, ok && w_ex && w_uni);
        end
        checks++;
        if ({busy, gate_ack} !== {1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL pulse_phase busy/ack: got %b %b expected 1 0000", busy, gate_ack);
        end
        if (car_entered === 1'b1) entered_cnt++;
        if (scramble) begin
            uni_is_vacated_space = 1'($urandom); is_vacated_space = 1'($urandom);
            uni_parked_car = 32'($urandom_range(0, 1)); parked_car = 32'($urandom_range(0, 1));
        end
        @(posedge clk); @(negedge clk);
        last_ack = gate_ack;
        last_accept = gate_accept;
        checks++;
        if (gate_ack !== exp_ack) begin
            errors++;
            $display("FAIL ack: got %b expected %b", gate_ack, exp_ack);
        end
        checks++;
        if (gate_accept !== ok) begin
            errors++;
            $display("FAIL accept gate%0d: got %b expected %b", w, gate_accept, ok);
        end
        checks++;
        if ({busy, car_entered, is_uni_car_enterd, car_exited, is_uni_car_exited} !== 5'b00000) begin
            errors++;
            $display("FAIL settle_phase busy/pulses: got %b%b%b%b%b expected 00000", busy,
                     car_entered, is_uni_car_enterd, car_exited, is_uni_car_exited);
        end
        rr_m = (w + 1) % 4;
        gate_req = 4'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        gate_req = 4'd0; gate_is_exit = 4'd0; gate_is_uni = 4'd0;
        uni_is_vacated_space = 1'b0; is_vacated_space = 1'b0;
        uni_parked_car = 32'd0; parked_car = 32'd0;
        #12;
        checks++;
        if ({gate_ack, gate_accept, car_entered, is_uni_car_enterd, car_exited,
             is_uni_car_exited, busy} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero ack=%b busy=%b", gate_ack, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        gate_req = 4'b0001; is_vacated_space = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_issue: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gate_ack, gate_accept, car_entered, is_uni_car_enterd, car_exited,
             is_uni_car_exited, busy} !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_issue: got ack=%b ent=%b busy=%b expected 0",
                     gate_ack, car_entered, busy);
        end
        gate_req = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_m = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({gate_ack, car_entered, car_exited, busy} !== 7'd0) begin
                errors++;
                $display("FAIL reset_abort cycle%0d: ack=%b ent=%b busy=%b expected 0",
                         c, gate_ack, car_entered, busy);
            end
        end
        do_txn(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [3:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        entered_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
            checks++;
            if (last_ack !== order[i]) begin
                errors++;
                $display("FAIL rr_order step%0d: got %b expected %b", i, last_ack, order[i]);
            end
            if (i == 3) begin
                checks++;
                if (entered_cnt !== 4) begin
                    errors++;
                    $display("FAIL rr_lap_entries: got %0d expected 4", entered_cnt);
                end
            end
        end
    endtask

    task automatic test_full_lot();
        apply_reset();
        do_txn(4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'd9, 32'd9, 1'b0);
        checks++;
        if ({last_ack, last_accept} !== {4'b0100, 1'b0}) begin
            errors++;
            $display("FAIL full_lot: ack=%b accept=%b expected 0100 0", last_ack, last_accept);
        end
        do_txn(4'b1001, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
        checks++;
        if (last_ack !== 4'b1000) begin
            errors++;
            $display("FAIL full_lot_rr_ptr: got %b expected 1000", last_ack);
        end
    endtask

    task automatic test_empty_exit();
        do_txn(4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, 32'd0, 32'd7, 1'b0);
        checks++;
        if ({last_ack, last_accept} !== {4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL empty_exit: ack=%b accept=%b expected 0010 0", last_ack, last_accept);
        end
        do_txn(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0, 32'd5, 32'd0, 1'b0);
        checks++;
        if ({last_ack, last_accept} !== {4'b0010, 1'b1}) begin
            errors++;
            $display("FAIL uni_exit_ok: ack=%b accept=%b expected 0010 1", last_ack, last_accept);
        end
    endtask

    task automatic test_type_flags();
        do_txn(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1, 32'd4, 32'd3, 1'b0);
        checks++;
        if (last_accept !== 1'b1) begin
            errors++;
            $display("FAIL ordinary_exit_accept: got %b expected 1", last_accept);
        end
    endtask

    task automatic test_exit_priority();
        logic [3:0] exp;
`ifdef EXIT_PRIORITY_EN
        exp = 4'b1000;
`else
        exp = 4'b0001;
`endif
        apply_reset();
        do_txn(4'b1001, 4'b1000, 4'b0000, 1'b1, 1'b1, 32'd1, 32'd1, 1'b0);
        checks++;
        if (last_ack !== exp) begin
            errors++;
            $display("FAIL exit_priority_first: got %b expected %b", last_ack, exp);
        end
    endtask

    task automatic test_random();
        logic [3:0] req;
        for (int i = 0; i < 60; i++) begin
            req = 4'($urandom);
            if (req == 4'd0) req = 4'b0100;
            do_txn(req, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom),
                   ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_full_lot();
        test_empty_exit();
        test_type_flags();
        test_exit_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
